register_bank_reader: RTL and testbench

//   Read-side sequencer for the 8-bit register bank on the shared data bus.

---
 rtl/register_bank_reader_pkg.sv | 26 ++
 rtl/register_bank_reader_addr_decoder.sv | 22 ++
 rtl/register_bank_reader.sv | 169 ++++++++++++++++
 tb/tb_register_bank_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_reader_pkg.sv
// Shared definitions for the register bank read sequencer: FSM state encoding,
// settle counter sizing and a small address helper.
package register_bank_reader_pkg;

  // FSM states; the fourth encoding is unreachable and recovers to idle.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSelect  = 2'd1,
    StHold    = 2'd2,
    StIllegal = 2'd3
  } reader_state_e;

  // Settle counter width covers the legal SETTLE range 1..15.
  localparam int unsigned SettleW   = 4;
  localparam int unsigned SettleMax = 15;

  // Next register address in a burst; wraps from the top register to zero.
  function automatic logic [7:0] next_addr(input logic [7:0] addr, input int unsigned addr_w);
    logic [7:0] sum;
    logic [7:0] mask;
    sum  = addr + 8'd1;
    mask = 8'((32'd1 << addr_w) - 32'd1);
    return sum & mask;
  endfunction

endpackage

// File: rtl/register_bank_reader_addr_decoder.sv
// Binary-to-one-hot address decoder with an enable. With the enable low the
// output is all-zero, so at most one register ever drives the shared bus.
// Kept generic so the write-side sequencer can reuse it.
module register_bank_reader_addr_decoder
  import register_bank_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 2
) (
  input  logic                     i_en,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic [(2**ADDR_W)-1:0]   o_onehot
);

  // Drive exactly one select bit when enabled, none otherwise.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/register_bank_reader.sv
// Read-side sequencer for the register bank on the shared data bus.
// Accepts a burst request (start address, length-1), selects one register at
// a time with a one-hot read enable, waits SETTLE cycles for the bus, captures
// the byte and offers it to the consumer over valid/ready.
module register_bank_reader
  import register_bank_reader_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned SETTLE = 1   // legal range 1..15
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [ADDR_W-1:0]      i_req_len,
  output logic [(2**ADDR_W)-1:0] o_rd_en,
  input  logic [WIDTH-1:0]       i_bus_data,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_last,
  output logic                   o_busy
);

  // Counter reload: SELECT lasts SETTLE cycles, capture happens when it hits 0.
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE - 1);

  reader_state_e       r_state;
  reader_state_e       w_state_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_remaining;
  logic [SettleW-1:0]  r_settle_cnt;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_out_last;

  logic                w_accept;
  logic                w_capture;
  logic                w_handshake;
  logic                w_advance;
  logic                w_sel_en;
  logic                w_settle_done;
  logic                w_last_beat;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign w_settle_done = (r_settle_cnt == '0);
  assign w_last_beat   = (r_remaining == '0);
  assign w_addr_inc    = ADDR_W'(next_addr(8'(r_addr), ADDR_W));

  // State register with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_state_next = StSelect;
        end
      end
      StSelect: begin
        if (w_settle_done) begin
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (r_out_valid && i_out_ready) begin
          w_state_next = w_last_beat ? StIdle : StSelect;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State-decoded outputs and internal strobes.
  always_comb begin
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    w_sel_en    = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      StIdle: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
        w_accept    = i_req_valid;
      end
      StSelect: begin
        w_sel_en  = 1'b1;
        w_capture = w_settle_done;
      end
      StHold: begin
        // out_ready only matters while a byte is actually on offer.
        w_handshake = r_out_valid && i_out_ready;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
    w_advance = w_handshake && !w_last_beat;
  end

  // Burst bookkeeping: latch the request, then step address and count per beat.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_addr      <= i_req_addr;
      r_remaining <= i_req_len;
    end else if (w_advance) begin
      r_addr      <= w_addr_inc;
      r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  // Settle counter: reloaded at the start of each beat, counts down in SELECT.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_settle_cnt <= '0;
    end else if (w_accept || w_advance) begin
      r_settle_cnt <= SettleLoad;
    end else if (w_sel_en && !w_settle_done) begin
      r_settle_cnt <= r_settle_cnt - SettleW'(1);
    end
  end

  // Output register: capture the bus on the final settle cycle, hold until taken.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= i_bus_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_last_beat;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;

  // Read enable is only ever driven while selecting, and always one-hot.
  register_bank_reader_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_rd_decoder (
    .i_en     (w_sel_en),
    .i_addr   (r_addr),
    .o_onehot (o_rd_en)
  );

endmodule

// File: tb/tb_register_bank_reader.sv
// Bench for register_bank_reader: a behavioural register bank drives the bus
// from the read enables; expected bytes come from the bank contents and burst
// arithmetic ((addr + beat) mod 4, last on beat == len).
module tb_register_bank_reader;

  localparam int unsigned S1 = 1;
  localparam int unsigned S3 = 3;

  logic       clk;
  logic       rst;

  logic       req_valid, req_ready, out_valid, out_ready, out_last, busy;
  logic [1:0] req_addr, req_len;
  logic [3:0] rd_en;
  logic [7:0] bus, out_data;
  logic [7:0] regs [4];

  logic       d3_req_valid, d3_req_ready, d3_out_valid, d3_out_ready, d3_out_last, d3_busy;
  logic [1:0] d3_req_addr, d3_req_len;
  logic [3:0] d3_rd_en;
  logic [7:0] d3_bus, d3_out_data;
  logic [7:0] regs3 [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: the selected register drives the bus, else a filler.
  always_comb begin
    bus = 8'hEE;
    for (int k = 0; k < 4; k++) if (rd_en[k]) bus = regs[k];
  end

  always_comb begin
    d3_bus = 8'hEE;
    for (int k = 0; k < 4; k++) if (d3_rd_en[k]) d3_bus = regs3[k];
  end

  register_bank_reader #(.WIDTH(8), .ADDR_W(2), .SETTLE(S1)) dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr(req_addr), .i_req_len(req_len), .o_rd_en(rd_en), .i_bus_data(bus),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_last(out_last), .o_busy(busy)
  );

  register_bank_reader #(.WIDTH(8), .ADDR_W(2), .SETTLE(S3)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(d3_req_valid), .o_req_ready(d3_req_ready),
    .i_req_addr(d3_req_addr), .i_req_len(d3_req_len), .o_rd_en(d3_rd_en),
    .i_bus_data(d3_bus), .o_out_data(d3_out_data), .o_out_valid(d3_out_valid),
    .i_out_ready(d3_out_ready), .o_out_last(d3_out_last), .o_busy(d3_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst on the SETTLE=1 instance, starting and ending on a negedge in IDLE.
  // stop_after >= 0 returns once that many beats have been handed over.
  task automatic run_burst(input int a, input int l, input int st_lo, input int st_hi,
                           input int stop_after);
    int         cyc, sel, ea, stall;
    logic [3:0] eoh;
    logic [7:0] exp_data;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = 2'(a);
    req_len   = 2'(l);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 2'($urandom);
    req_len   = 2'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int b = 0; b <= l; b++) begin
      if (b == stop_after) return;
      ea       = (a + b) % 4;
      eoh      = 4'(1 << ea);
      exp_data = regs[ea];
      cyc      = 1;
      sel      = 0;
      while (!out_valid && cyc < 40) begin
        if (rd_en == eoh) sel++;
        else check("rd_en_value", 32'(rd_en), 32'(eoh));
        out_ready = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
      out_ready = 1'b0;
      check("out_valid_rise", 32'(out_valid), 32'd1);
      check("latency", 32'(cyc - 1), S1);
      check("select_cycles", 32'(sel), S1);
      check("out_data", 32'(out_data), 32'(exp_data));
      check("out_last", 32'(out_last), 32'(b == l));
      check("rd_en_hold", 32'(rd_en), 32'd0);
      check("req_ready_hold", 32'(req_ready), 32'd0);
      stall = $urandom_range(st_hi, st_lo);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(exp_data));
        check("stall_rd_en", 32'(rd_en), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", 32'(out_valid), 32'd0);
      if (b == l) begin
        check("end_req_ready", 32'(req_ready), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_rd_en", 32'(rd_en), 32'd0);
      end
    end
  endtask

  // Watchdog: the bench must never hang on a stuck DUT.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b0;
    d3_req_valid = 1'b0; d3_req_addr = '0; d3_req_len = '0; d3_out_ready = 1'b0;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    regs3[0] = 8'hA0; regs3[1] = 8'hA1; regs3[2] = 8'hA2; regs3[3] = 8'hA3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_d3_rd_en", 32'(d3_rd_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single read, wrap burst, backpressured burst.
    run_burst(2, 0, 0, 0, -1);
    run_burst(3, 3, 0, 0, -1);
    run_burst(0, 2, 5, 5, -1);

    // SETTLE=3: bus moves during SELECT, the third cycle's value is captured.
    d3_req_valid = 1'b1; d3_req_addr = 2'd1; d3_req_len = 2'd0;
    @(posedge clk);
    @(negedge clk);
    d3_req_valid = 1'b0;
    check("s3_sel1_rd_en", 32'(d3_rd_en), 32'h2);
    check("s3_sel1_valid", 32'(d3_out_valid), 32'd0);
    @(negedge clk);
    regs3[1] = 8'h5C;
    check("s3_sel2_rd_en", 32'(d3_rd_en), 32'h2);
    check("s3_sel2_valid", 32'(d3_out_valid), 32'd0);
    @(negedge clk);
    regs3[1] = 8'hC5;
    check("s3_sel3_valid", 32'(d3_out_valid), 32'd0);
    @(negedge clk);
    check("s3_valid", 32'(d3_out_valid), 32'd1);
    check("s3_data", 32'(d3_out_data), 32'hC5);
    check("s3_last", 32'(d3_out_last), 32'd1);
    check("s3_rd_en_hold", 32'(d3_rd_en), 32'd0);
    d3_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d3_out_ready = 1'b0;
    check("s3_idle", 32'(d3_req_ready), 32'd1);

    // Request held high through the last beat's HOLD: taken only once idle.
    req_valid = 1'b1; req_addr = 2'd2; req_len = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 2'd0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_req_valid", 32'(out_valid), 32'd1);
    check("hold_data", 32'(out_data), 32'h33);
    repeat (2) @(negedge clk);
    check("hold_req_ready", 32'(req_ready), 32'd0);
    check("hold_rd_en", 32'(rd_en), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("gap_req_ready", 32'(req_ready), 32'd1);
    check("gap_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("second_rd_en", 32'(rd_en), 32'h1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("second_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after the second byte of a four-byte burst.
    run_burst(0, 3, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_en", 32'(rd_en), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    run_burst(1, 0, 0, 0, -1);

    // Randomized bursts against the bank contents.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 4; k++) regs[k] = 8'($urandom);
      run_burst(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 0, 3, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
